mips_mc_control_fsm: RTL and testbench
======================================

Name: mips_mc_control_fsm

Overview:
- Main control state machine for the multi-cycle, non-pipelined MIPS core.
- Drives the PC register's load enable and selects its next-PC source.
- Sequences instruction memory, instruction register, register file and ALU through fetch/decode/execute/memory/writeback.
- Handles one instruction at a time; completion always returns to FETCH.

Parameters:
OPCODE_WIDTH, 6, instruction opcode field width (bits 31:26).
STATE_WIDTH, 4, width of the state debug output.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  OPCODE_WIDTH  opcode from instruction register, stable after FETCH completes
zero  input  1  ALU zero flag, valid combinationally in BRANCH
mem_ready  input  1  memory access completes this cycle
pc_en  output  1  PC register load enable = pc_write OR (pc_write_cond AND zero)
pc_src  output  2  next-PC select: 00 ALU result, 01 ALUOut (branch target), 10 jump target
iord  output  1  memory address select: 0 PC, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
reg_dst  output  1  write register select: 0 rt, 1 rd
mem_to_reg  output  1  writeback data select: 0 ALUOut, 1 MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select: 0 PC, 1 register A
alu_src_b  output  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm shifted left 2
alu_op  output  2  00 add, 01 subtract, 10 use funct field
illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
state_dbg  output  STATE_WIDTH  current state encoding

Behaviour:
- Moore outputs decoded from the state register.
- Exceptions to Moore decoding: pc_en in FETCH and BRANCH, ir_write in FETCH, and illegal_op in DECODE also depend on inputs.
- Any output not listed for a state is 0.
- Reset (rst_n low, asynchronous): state = START (0); all outputs 0; state_dbg = 0.
- START: no outputs asserted; next cycle goes to FETCH.
- FETCH:
  - Asserts mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
  - PC is therefore loaded with PC+4 exactly once per instruction.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 / 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - any other opcode -> FETCH with illegal_op=1 for this cycle; PC is not modified.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
- MEM_WRITE: mem_write=1, iord=1. Waits for mem_ready, then goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: reg_dst=1, reg_write=1. Goes to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1, so pc_en=zero.
  - Goes to FETCH.
- JUMP: pc_src=10, pc_en=1. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1. Goes to FETCH.
- Instruction latency in cycles, each extra memory wait adding 1:
  - R-type / addi: 4
  - beq / j: 3
  - sw: 4
  - lw: 5
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and pc_en are never both 1.
  - opcode is ignored outside DECODE and MEM_ADDR.
- Unused state encodings go to FETCH on the next edge with all outputs 0.
- Reset mid-instruction: immediate return to START. No write strobe may remain high during or after reset.

Test Plan:
- Reset, then mem_ready=1 constantly -> state_dbg START then FETCH. In FETCH: pc_en=1, ir_write=1, mem_read=1, alu_src_b=01.
- opcode=000000, mem_ready=1 -> FETCH, DECODE, EXECUTE (alu_op=10), R_WB (reg_write=1, reg_dst=1), FETCH; 4 cycles total.
- lw (100011) with mem_ready held 0 for 2 cycles in MEM_READ:
  - iord=1 and mem_read=1 held for 3 cycles.
  - Then MEM_WB with mem_to_reg=1, reg_write=1.
  - 7 cycles total.
- beq (000100) -> in BRANCH, zero=1 gives pc_en=1, pc_src=01; repeat with zero=0 gives pc_en=0; both return to FETCH.
- opcode=111111 -> DECODE asserts illegal_op for exactly 1 cycle, pc_en=0, next state FETCH; j (000010) -> JUMP asserts pc_en=1, pc_src=10.
- sw with mem_ready=0, rst_n pulsed low during MEM_WRITE -> mem_write drops asynchronously, state START, all outputs 0; after release, the next cycle is FETCH.

Source files
------------

// File: rtl/mips_mc_control_fsm.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode, execute,
// memory and writeback, and drives the PC load enable and datapath selects.
module mips_mc_control_fsm #(
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned STATE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    pc_en,
    output logic [1:0]              pc_src,
    output logic                    iord,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic                    illegal_op,
    output logic [STATE_WIDTH-1:0]  state_dbg
);

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);

    typedef enum logic [3:0] {
        S_START     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    state_t state;
    state_t state_next;
    logic   pc_write;
    logic   pc_write_cond;

    // State register; reset forces START so every strobe decodes low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next    = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;

        case (state)
            S_START: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    state_next = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_next = S_MEM_WRITE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM_READ: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_src        = 2'b01;
                pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign pc_en     = pc_write | (pc_write_cond & zero);
    assign state_dbg = STATE_WIDTH'(state);

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Bench for mips_mc_control_fsm: per-instruction step model, directed latency and
// reset cases, then randomized instruction streams with random memory stalls.
module tb_mips_mc_control_fsm;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state_dbg;
    ctl_t       dut_c;

    int   checks = 0;
    int   errors = 0;
    int   step;   // -1 idle after reset, 0 fetch, 1 decode, 2.. instruction-specific steps
    int   kind;
    ctl_t last;

    mips_mc_control_fsm #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    assign dut_c = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op);
        case (op)
            OP_R:         return K_R;
            OP_LW:        return K_LW;
            OP_SW:        return K_SW;
            OP_BEQ:       return K_BEQ;
            OP_J:         return K_J;
            OP_ADDI:      return K_ADDI;
            default:      return K_ILL;
        endcase
    endfunction

    // Control word an instruction needs at a given step of its execution.
    function automatic ctl_t expect_ctl(input int st, input int k, input logic [5:0] op,
                                        input logic mr, input logic z);
        ctl_t e = '0;
        if (st == 0) begin
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            e.ir_write  = mr;
            e.pc_en     = mr;
        end else if (st == 1) begin
            e.alu_src_b  = 2'b11;
            e.illegal_op = (classify(op) == K_ILL);
        end else if (st == 2) begin
            if (k == K_R) begin
                e.alu_src_a = 1'b1; e.alu_op = 2'b10;
            end else if (k == K_LW || k == K_SW || k == K_ADDI) begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            end else if (k == K_BEQ) begin
                e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z;
            end else if (k == K_J) begin
                e.pc_src = 2'b10; e.pc_en = 1'b1;
            end
        end else if (st == 3) begin
            if (k == K_R) begin
                e.reg_dst = 1'b1; e.reg_write = 1'b1;
            end else if (k == K_ADDI) begin
                e.reg_write = 1'b1;
            end else if (k == K_LW) begin
                e.mem_read = 1'b1; e.iord = 1'b1;
            end else if (k == K_SW) begin
                e.mem_write = 1'b1; e.iord = 1'b1;
            end
        end else if (st == 4) begin
            e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
        end
        return e;
    endfunction

    task automatic advance(input logic [5:0] op, input logic mr);
        if (!rst_n) begin
            step = -1;
        end else if (step == -1) begin
            step = 0;
        end else if (step == 0) begin
            step = mr ? 1 : 0;
        end else if (step == 1) begin
            kind = classify(op);
            step = (kind == K_ILL) ? 0 : 2;
        end else if (step == 2) begin
            step = (kind == K_BEQ || kind == K_J) ? 0 : 3;
        end else if (step == 3) begin
            if (kind == K_LW)      step = mr ? 4 : 3;
            else if (kind == K_SW) step = mr ? 0 : 3;
            else                   step = 0;
        end else begin
            step = 0;
        end
    endtask

    // One clock: drive at the falling edge, compare, then step the model at the rising edge.
    task automatic cycle(input logic [5:0] op, input logic mr, input logic z);
        @(negedge clk);
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        #1;
        chk("ctl", 32'(dut_c), 32'(expect_ctl(step, kind, op, mr, z)));
        chk("state_dbg_start", 32'(state_dbg == 4'd0), 32'(step < 0));
        chk("invariant", 32'({mem_read & mem_write, reg_write & pc_en}), 32'd0);
        last = dut_c;
        @(posedge clk);
        advance(op, mr);
    endtask

    // Runs one instruction from FETCH, stalling memory steps `waits` times; stops at next FETCH.
    task automatic run_instr(input logic [5:0] op, input int waits, input logic z,
                             output int lat, output int n_rd, output int n_br,
                             output int n_j, output int n_ill, output ctl_t first);
        int   w = waits;
        logic mr;
        bit   done = 0;
        lat = 0; n_rd = 0; n_br = 0; n_j = 0; n_ill = 0;
        first = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            mr = 1'b1;
            if (i > 0 && step == 0) mr = 1'b0;
            if (step == 3 && (kind == K_LW || kind == K_SW) && w > 0) begin
                mr = 1'b0;
                w--;
            end
            cycle(op, mr, z);
            if (i == 0) first = last;
            if (i > 0 && last.mem_read && !last.iord) begin
                done = 1;
            end else begin
                lat++;
                if (last.iord && last.mem_read) n_rd++;
                if (last.pc_en && last.pc_src == 2'b01) n_br++;
                if (last.pc_en && last.pc_src == 2'b10) n_j++;
                if (last.illegal_op) n_ill++;
            end
        end
        if (!done) chk("instr_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   lat, n_rd, n_br, n_j, n_ill;
        ctl_t first;
        logic [5:0] op;
        logic [5:0] ops [6];
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;

        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
        step = -1; kind = K_R; last = '0;
        #1;
        chk("reset_outputs", 32'(dut_c), 32'd0);
        chk("reset_state_dbg", 32'(state_dbg), 32'd0);
        cycle(OP_R, 1'b1, 1'b0);
        cycle(OP_R, 1'b1, 1'b0);
        #1 rst_n = 1'b1;
        cycle(OP_R, 1'b1, 1'b0);

        run_instr(OP_R, 0, 1'b0, lat, n_rd, n_br, n_j, n_ill, first);
        chk("fetch_lit", 32'({first.pc_en, first.ir_write, first.mem_read, first.alu_src_b}), 32'b11101);
        chk("rtype_latency", 32'(lat), 32'd4);

        run_instr(OP_LW, 2, 1'b0, lat, n_rd, n_br, n_j, n_ill, first);
        chk("lw_latency", 32'(lat), 32'd7);
        chk("lw_read_cycles", 32'(n_rd), 32'd3);

        run_instr(OP_BEQ, 0, 1'b1, lat, n_rd, n_br, n_j, n_ill, first);
        chk("beq_taken_latency", 32'(lat), 32'd3);
        chk("beq_taken_pc_en", 32'(n_br), 32'd1);
        run_instr(OP_BEQ, 0, 1'b0, lat, n_rd, n_br, n_j, n_ill, first);
        chk("beq_not_taken_pc_en", 32'(n_br), 32'd0);

        run_instr(OP_BAD, 0, 1'b0, lat, n_rd, n_br, n_j, n_ill, first);
        chk("illegal_pulses", 32'(n_ill), 32'd1);
        chk("illegal_latency", 32'(lat), 32'd2);

        run_instr(OP_J, 0, 1'b0, lat, n_rd, n_br, n_j, n_ill, first);
        chk("jump_pc_en", 32'(n_j), 32'd1);
        chk("jump_latency", 32'(lat), 32'd3);

        run_instr(OP_ADDI, 0, 1'b0, lat, n_rd, n_br, n_j, n_ill, first);
        chk("addi_latency", 32'(lat), 32'd4);
        run_instr(OP_SW, 0, 1'b0, lat, n_rd, n_br, n_j, n_ill, first);
        chk("sw_latency", 32'(lat), 32'd4);

        // Store stalled in its memory step, then reset asserted mid-cycle.
        cycle(OP_SW, 1'b1, 1'b0);
        cycle(OP_SW, 1'b0, 1'b0);
        cycle(OP_SW, 1'b0, 1'b0);
        cycle(OP_SW, 1'b0, 1'b0);
        chk("sw_stall_mem_write", 32'(last.mem_write), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_c), 32'd0);
        chk("async_reset_state", 32'(state_dbg), 32'd0);
        step = -1;
        cycle(OP_SW, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        cycle(OP_R, 1'b1, 1'b0);
        cycle(OP_R, 1'b0, 1'b0);
        chk("post_reset_fetch", 32'({last.mem_read, 1'b0 | (state_dbg != 4'd0)}), 32'b11);

        op = OP_R;
        for (int n = 0; n < 2000; n++) begin
            if (step == 0) begin
                int idx = int'($urandom_range(0, 7));
                op = (idx < 6) ? ops[idx] : 6'($urandom);
            end
            cycle(op, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
